// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer: two-requester round-robin front end for a shared ALU.
// Divides run in an internal restoring divider; other ops use the ALU.
module alu_rr_sequencer #(
  parameter int          DATA_W = 16,
  parameter logic [2:0]  OP_DIV = 3'b011
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_W-1:0]     req0_a,
  input  logic [DATA_W-1:0]     req0_b,
  input  logic [2:0]            req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_W-1:0]     req1_a,
  input  logic [DATA_W-1:0]     req1_b,
  input  logic [2:0]            req1_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*DATA_W-1:0]   rsp_data,
  output logic                  rsp_id,
  output logic                  rsp_div0,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [2:0]            alu_op,
  input  logic [2*DATA_W-1:0]   alu_out,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DIV,
    RESP
  } state_t;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t            state;
  logic              ptr;
  logic              cur_id;
  logic              div0_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;

  logic              g0;
  logic              g1;
  logic              accept;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [2:0]        sel_op;

  logic [DATA_W:0]   trial;
  logic              fits;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;

  // Round-robin grant: pointer only matters when both requesters are valid.
  always_comb begin
    g0 = req0_valid && (!req1_valid || !ptr);
    g1 = req1_valid && (!req0_valid || ptr);
    req0_ready = !rst && (state == IDLE) && g0;
    req1_ready = !rst && (state == IDLE) && g1;
    accept = req0_ready || req1_ready;
    sel_a  = g1 ? req1_a  : req0_a;
    sel_b  = g1 ? req1_b  : req0_b;
    sel_op = g1 ? req1_op : req0_op;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial   = {rem, quo[DATA_W-1]};
    fits    = trial >= {1'b0, alu_b};
    rem_nxt = fits ? DATA_W'(trial - {1'b0, alu_b})
                   : trial[DATA_W-1:0];
    quo_nxt = {quo[DATA_W-2:0], fits};
  end

  // Sequencer FSM with registered response and ALU operand outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cur_id    <= 1'b0;
      div0_q    <= 1'b0;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_div0  <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            alu_op <= sel_op;
            cur_id <= g1;
            ptr    <= !g1;
            busy   <= 1'b1;
            quo    <= sel_a;
            rem    <= '0;
            cnt    <= '0;
            div0_q <= (sel_b == '0);
            if (sel_op == OP_DIV) state <= DIV;
            else                  state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_div0  <= 1'b0;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        DIV: begin
          if (div0_q) begin
            rsp_data  <= {alu_a, {DATA_W{1'b1}}};
            rsp_div0  <= 1'b1;
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              rsp_data  <= {rem_nxt, quo_nxt};
              rsp_div0  <= 1'b0;
              rsp_id    <= cur_id;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// tb_alu_rr_sequencer: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_alu_rr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [15:0] req0_a, req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_a, req1_b;
  logic [2:0]  req1_op;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id, rsp_div0;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_out;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_rr_sequencer #(.DATA_W(16), .OP_DIV(3'b011)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_div0(rsp_div0),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .busy(busy)
  );

  function automatic logic [31:0] tb_alu(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [2:0] op);
    case (op)
      3'b000:  return 32'(a) + 32'(b);
      3'b001:  return 32'(a) - 32'(b);
      3'b010:  return 32'(a) * 32'(b);
      3'b100:  return 32'(a & b);
      3'b101:  return 32'(a | b);
      3'b110:  return 32'(a ^ b);
      3'b111:  return {b, a};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_out = tb_alu(alu_a, alu_b, alu_op);

  function automatic logic [31:0] model(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic [2:0] op);
    if (op != 3'b011) return tb_alu(a, b, op);
    if (b == 16'd0)   return {a, 16'hFFFF};
    return {a % b, a / b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp_ready  = 1;
  endtask

  task automatic do_reset;
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic drive(input logic id, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] op);
    if (id) begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [31:0] exp;
    logic        div0;
    int          lat;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        div0;
  } exp_t;

  task automatic run_vec(input vec_t v);
    int  n;
    logic bok;
    drive(v.id, v.a, v.b, v.op);
    rsp_ready = 1;
    @(negedge clk);
    chk("vec_ready", {req1_ready, req0_ready},
        v.id ? 32'd2 : 32'd1);
    tick();
    req0_valid = 0;
    req1_valid = 0;
    n = 0;
    bok = 1;
    while (!rsp_valid && n < 40) begin
      if (!busy) bok = 0;
      tick();
      n++;
    end
    chk("vec_latency", n, v.lat);
    chk("vec_data", rsp_data, v.exp);
    chk("vec_id", rsp_id, v.id);
    chk("vec_div0", rsp_div0, v.div0);
    chk("vec_busy", bok & busy, 1);
    tick();
    chk("vec_rsp_clear", {rsp_valid, busy}, 0);
  endtask

  vec_t vt[9];

  initial begin
    int   n;
    logic ok;
    logic pref;
    logic g, eg;
    logic pv[2];
    logic [15:0] pa[2], pb[2];
    logic [2:0]  po[2];
    exp_t q[$];
    exp_t e;

    vt[0] = '{1'b0, 16'h1234, 16'h0001, 3'b000, 32'h0000_1235, 1'b0, 1};
    vt[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 3'b010, 32'hFFFE_0001, 1'b0, 1};
    vt[2] = '{1'b0, 16'd100,  16'd7,    3'b011, 32'h0002_000E, 1'b0, 16};
    vt[3] = '{1'b1, 16'h0005, 16'h0000, 3'b011, 32'h0005_FFFF, 1'b1, 1};
    vt[4] = '{1'b0, 16'h0003, 16'h0005, 3'b001, 32'hFFFF_FFFE, 1'b0, 1};
    vt[5] = '{1'b1, 16'hA5A5, 16'h0FF0, 3'b110, 32'h0000_AA55, 1'b0, 1};
    vt[6] = '{1'b0, 16'hFFFF, 16'h0001, 3'b011, 32'h0000_FFFF, 1'b0, 16};
    vt[7] = '{1'b1, 16'd7,    16'd100,  3'b011, 32'h0007_0000, 1'b0, 16};
    vt[8] = '{1'b0, 16'hFFFF, 16'hFFFF, 3'b011, 32'h0000_0001, 1'b0, 16};

    // reset state
    rst = 1;
    idle_inputs();
    req0_valid = 1;
    req1_valid = 1;
    #1;
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    chk("rst_outs", {rsp_valid, rsp_id, rsp_div0, busy}, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_alu", {alu_op, alu_b, alu_a}, 0);
    do_reset();

    foreach (vt[i]) run_vec(vt[i]);

    // both valid after reset: req0 first, then req1
    do_reset();
    drive(0, 16'hFFFF, 16'hFFFF, 3'b010);
    drive(1, 16'd3, 16'd4, 3'b000);
    @(negedge clk);
    chk("both_ready0", {req1_ready, req0_ready}, 1);
    tick();
    req0_valid = 0;
    ok = 1;
    n = 0;
    while (!rsp_valid && n < 40) begin
      if (req1_ready) ok = 0;
      tick();
      n++;
    end
    chk("both_r1_blocked", ok, 1);
    chk("both_data0", rsp_data, 32'hFFFE_0001);
    chk("both_id0", rsp_id, 0);
    @(negedge clk);
    chk("both_resp_ready", {req1_ready, req0_ready}, 0);
    tick();
    @(negedge clk);
    chk("both_ready1", {req1_ready, req0_ready}, 2);
    tick();
    req1_valid = 0;
    wait_rsp(n);
    chk("both_data1", rsp_data, 32'h0000_0007);
    chk("both_id1", rsp_id, 1);
    tick();

    // backpressure
    do_reset();
    rsp_ready = 0;
    drive(0, 16'd1, 16'd2, 3'b000);
    tick();
    req0_valid = 0;
    drive(1, 16'd10, 16'd20, 3'b000);
    wait_rsp(n);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_data", rsp_data, 32'd3);
      chk("bp_valid_r1", {rsp_valid, req1_ready}, 2);
      tick();
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_hs_ready", req1_ready, 0);
    tick();
    @(negedge clk);
    chk("bp_next_ready", req1_ready, 1);
    tick();
    req1_valid = 0;
    wait_rsp(n);
    chk("bp_data1", rsp_data, 32'd30);
    chk("bp_id1", rsp_id, 1);
    tick();

    // reset in the middle of a divide
    do_reset();
    drive(0, 16'd100, 16'd7, 3'b011);
    tick();
    req0_valid = 0;
    repeat (7) tick();
    chk("mid_busy", {busy, alu_a}, {16'd0, 1'b1, 16'd100});
    req0_valid = 1;
    req1_valid = 1;
    rst = 1;
    #1;
    chk("mid_rst_outs", {rsp_valid, busy, rsp_div0, rsp_id}, 0);
    chk("mid_rst_alu", {alu_op, alu_b, alu_a}, 0);
    chk("mid_rst_ready", {req1_ready, req0_ready}, 0);
    req0_valid = 0;
    req1_valid = 0;
    @(posedge clk);
    #1;
    rst = 0;
    ok = 1;
    repeat (25) begin
      if (rsp_valid) ok = 0;
      tick();
    end
    chk("mid_no_rsp", ok, 1);
    drive(0, 16'd9, 16'd1, 3'b000);
    drive(1, 16'd8, 16'd1, 3'b000);
    @(negedge clk);
    chk("mid_grant0", {req1_ready, req0_ready}, 1);
    tick();
    req0_valid = 0;
    req1_valid = 0;
    wait_rsp(n);
    chk("mid_data", rsp_data, 32'd10);
    tick();

    // randomized traffic against the transaction model
    do_reset();
    pref = 0;
    pv[0] = 0;
    pv[1] = 0;
    for (int c = 0; c < 650; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (c < 600 && !pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1;
          pa[i] = 16'($urandom);
          pb[i] = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
          po[i] = 3'($urandom_range(0, 7));
        end
      end
      req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = po[0];
      req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = po[1];
      rsp_ready = (c >= 600) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("rnd_one_ready", req0_ready & req1_ready, 0);
      chk("rnd_ready_idle", req0_ready | req1_ready,
          !busy && (pv[0] || pv[1]));
      if ((pv[0] && req0_ready) || (pv[1] && req1_ready)) begin
        g  = req1_ready;
        eg = (pv[0] && pv[1]) ? pref : pv[1];
        chk("rnd_grant", g, eg);
        e.id   = g;
        e.data = model(pa[g], pb[g], po[g]);
        e.div0 = (po[g] == 3'b011) && (pb[g] == 16'd0);
        q.push_back(e);
        pref  = !g;
        pv[g] = 0;
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_rsp", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rnd_data", rsp_data, e.data);
          chk("rnd_id", rsp_id, e.id);
          chk("rnd_div0", rsp_div0, e.div0);
        end
      end
      @(posedge clk);
      #1;
    end
    chk("rnd_drained", q.size(), 0);
    chk("rnd_final_idle", {rsp_valid, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_rr_sequencer.md
Name: alu_rr_sequencer

Overview:
- Shares one combinational 16-bit ALU between two requesters using round-robin arbitration.
- Single-cycle ops are issued to the external ALU and its result is registered.
- Op 3'b011 (divide) runs in an internal restoring divider that returns quotient and remainder together, because the ALU cannot deliver both.
- Sits between the requesting units and the ALU. Returns one tagged response per accepted request over a valid/ready channel.

Parameters:
- DATA_W, 16: operand width. Result width is 2*DATA_W. Divider iteration count is DATA_W.
- OP_DIV, 3'b011: op code routed to the internal divider. All other codes go to the ALU.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_a  in  DATA_W  operand A.
- req0_b  in  DATA_W  operand B.
- req0_op  in  3  op code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  2*DATA_W  result.
- rsp_id  out  1  index of the requester that issued the request.
- rsp_div0  out  1  divide-by-zero flag.
- alu_a  out  DATA_W  latched operand A to the ALU.
- alu_b  out  DATA_W  latched operand B to the ALU.
- alu_op  out  3  latched op to the ALU.
- alu_out  in  2*DATA_W  ALU result, combinational from alu_a, alu_b and alu_op.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (async, immediate): state IDLE; rsp_valid, rsp_data, rsp_id, rsp_div0, alu_a, alu_b, alu_op, busy all 0; priority pointer = 0; divider counter = 0.
- req0_ready and req1_ready are forced to 0 while rst is high.
- States: IDLE, EXEC, DIV, RESP.
- IDLE, grant:
  - Only one requester valid: it is granted.
  - Both valid: the requester named by the pointer is granted.
  - reqN_ready = (state==IDLE) && granted N. This is combinational, and at most one ready is high.
  - Handshake completes when valid&&ready at a rising edge (edge E0).
  - At E0: latch A, B, op into alu_a, alu_b, alu_op; latch the requester id; pointer = other requester.
- IDLE, next state:
  - op != OP_DIV: go to EXEC.
  - op == OP_DIV and B != 0: go to DIV with counter = 0.
  - op == OP_DIV and B == 0: go to DIV and flag div0.
- EXEC (one cycle): at the next edge E1, rsp_data <= alu_out, rsp_div0 <= 0, go to RESP. rsp_valid is high from E1.
- DIV, normal divide:
  - One restoring shift/subtract step per cycle, DATA_W steps.
  - After the last step, rsp_data = {remainder, quotient}, with remainder in the upper half. rsp_valid is high from edge E16 (DATA_W=16).
- DIV, B == 0:
  - Lasts one cycle. rsp_data = {A, 16'hFFFF}, rsp_div0 = 1. rsp_valid is high from E1.
- RESP:
  - rsp_valid, rsp_data, rsp_id and rsp_div0 hold stable until rsp_ready is high at an edge.
  - At that edge: rsp_valid <= 0 and go to IDLE. A new grant is possible in the cycle after the response handshake, not in the same cycle.
- Requesters must hold valid and payload stable until accepted. Ready never depends on rsp_ready.
- alu_* outputs keep their last latched values after the op completes.
- Width: results are passed through from alu_out with no modification. Divide is unsigned.
- Reset mid-operation (any state): the in-flight transaction is dropped with no response, and all reset values apply.

Test Plan:
- After reset, req0 only, A=0x1234, B=0x0001, op=000, rsp_ready=1 -> req0_ready high in the first cycle; rsp_valid one cycle after accept; rsp_data=0x00001235, rsp_id=0, rsp_div0=0.
- Both valid after reset, req0 op=010 with 0xFFFF*0xFFFF, req1 op=000 with 3+4 -> req0 served first with 0xFFFE0001, then req1 with 0x00000007 and rsp_id=1; ready never high for both in the same cycle.
- Divide op=011, A=100, B=7 -> rsp_valid exactly 16 cycles after accept; rsp_data=0x0002000E; busy high throughout.
- Divide A=0x0005, B=0 -> rsp_valid one cycle after accept; rsp_data=0x0005FFFF; rsp_div0=1.
- Backpressure: rsp_ready low for 3 cycles while req1 is valid -> rsp_data stable, req1_ready stays 0; after rsp_ready=1, req1 is accepted the following cycle.
- Assert rst at cycle 8 of a divide -> all outputs return to reset values immediately; no response is emitted; the next simultaneous request grants req0 first.
